// File: rtl/libv_base_sacc.sv
// Saturating block accumulator: sums LEN valid signed samples with per-step
// saturation and emits one registered result pulse per block with an overflow flag.
module libv_base_sacc #(
  parameter int WI  = 11,
  parameter int WO  = 16,
  parameter int LEN = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_vld,
  input  logic [WI-1:0] in_dat,
  output logic          out_vld,
  output logic [WO-1:0] out_dat,
  output logic          out_ovf
);

  localparam int CW = $clog2(LEN + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACC  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [WO-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          out_vld_q, out_vld_d;
  logic [WO-1:0] out_dat_q, out_dat_d;
  logic          out_ovf_q, out_ovf_d;

  logic [WO:0]   sum;
  logic          sat;
  logic [WO-1:0] step;
  logic          last;

  // One guard bit is enough: the sign of the WO+1 sum is always correct.
  always_comb begin
    sum  = {acc_q[WO-1], acc_q} + {{(WO + 1 - WI){in_dat[WI-1]}}, in_dat};
    sat  = sum[WO] ^ sum[WO-1];
    step = sat ? {sum[WO], {(WO - 1){~sum[WO]}}} : sum[WO-1:0];
    last = (cnt_q == CW'(LEN - 1));
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_vld_d = 1'b0;
    out_dat_d = out_dat_q;
    out_ovf_d = out_ovf_q;
    if (clr) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (in_vld) begin
      if (last) begin
        out_vld_d = 1'b1;
        out_dat_d = step;
        out_ovf_d = ovf_q | sat;
        state_d   = S_IDLE;
        acc_d     = '0;
        cnt_d     = '0;
        ovf_d     = 1'b0;
      end else begin
        state_d = S_ACC;
        acc_d   = step;
        cnt_d   = cnt_q + CW'(1);
        ovf_d   = ovf_q | sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign out_vld = out_vld_q;
  assign out_dat = out_dat_q;
  assign out_ovf = out_ovf_q;

endmodule

// File: tb/tb_libv_base_sacc.sv
// Directed bench for libv_base_sacc: three instances (default, WO=12, WO=12/LEN=4)
// share one stimulus stream; each test resets first and checks the relevant instance.
module tb_libv_base_sacc;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_vld;
  logic [10:0] in_dat;

  logic               vld_a, vld_b, vld_c;
  logic signed [15:0] dat_a;
  logic signed [11:0] dat_b, dat_c;
  logic               ovf_a, ovf_b, ovf_c;

  int vectors = 0;
  int errs    = 0;
  int pulses  = 0;
  int ticks   = 0;
  int first_t, second_t;

  always #5 clk = ~clk;

  libv_base_sacc u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_dat(in_dat),
    .out_vld(vld_a), .out_dat(dat_a), .out_ovf(ovf_a)
  );

  libv_base_sacc #(.WI(11), .WO(12), .LEN(8)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_dat(in_dat),
    .out_vld(vld_b), .out_dat(dat_b), .out_ovf(ovf_b)
  );

  libv_base_sacc #(.WI(11), .WO(12), .LEN(4)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_dat(in_dat),
    .out_vld(vld_c), .out_dat(dat_c), .out_ovf(ovf_c)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; counts pulses of instance a.
  task automatic tick();
    @(posedge clk);
    #1;
    ticks++;
    if (vld_a === 1'b1) pulses++;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    clr    = 1'b0;
    in_vld = 1'b0;
    in_dat = '0;
    tick();
    rst_n  = 1'b1;
  endtask

  task automatic feed(input int n, input int val);
    for (int i = 0; i < n; i++) begin
      in_vld = 1'b1;
      in_dat = 11'(val);
      tick();
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_vld", vld_a, 0);
    chk("rst_dat", dat_a, 0);
    chk("rst_ovf", ovf_a, 0);

    // T1: 8x +100, continuous
    feed(7, 100);
    chk("t1_no_early_vld", vld_a, 0);
    feed(1, 100);
    chk("t1_vld", vld_a, 1);
    chk("t1_dat", dat_a, 800);
    chk("t1_ovf", ovf_a, 0);
    in_vld = 1'b0;
    in_dat = 'x;
    tick();
    chk("t1_pulse_1clk", vld_a, 0);
    chk("t1_hold_dat", dat_a, 800);

    // T2: WO=12, 8x +1023 then back-to-back 8x -1024
    do_reset();
    feed(8, 1023);
    chk("t2_pos_vld", vld_b, 1);
    chk("t2_pos_dat", dat_b, 2047);
    chk("t2_pos_ovf", ovf_b, 1);
    chk("t2_wide_dat", dat_a, 8184);
    chk("t2_wide_ovf", ovf_a, 0);
    feed(1, -1024);
    chk("t2_b2b_vld_low", vld_b, 0);
    chk("t2_b2b_hold", dat_b, 2047);
    feed(7, -1024);
    chk("t2_neg_vld", vld_b, 1);
    chk("t2_neg_dat", dat_b, -2048);
    chk("t2_neg_ovf", ovf_b, 1);
    chk("t2_wide_neg", dat_a, -8192);

    // T3: WO=12, LEN=4, per-step saturation makes the result order dependent
    do_reset();
    feed(3, 1023);
    feed(1, -1024);
    chk("t3_vld", vld_c, 1);
    chk("t3_dat", dat_c, 1023);
    chk("t3_ovf", ovf_c, 1);

    // T4: 8x -5 with random gaps, X on in_dat during gaps
    do_reset();
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      int gap;
      gap = int'($urandom_range(3, 0));
      for (int g = 0; g < gap; g++) begin
        in_vld = 1'b0;
        in_dat = 'x;
        tick();
      end
      feed(1, -5);
    end
    in_vld = 1'b0;
    in_dat = 'x;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_pulses", pulses, 1);
    chk("t4_dat", dat_a, -40);
    chk("t4_ovf", ovf_a, 0);

    // T5: clr after 5x +7 (with in_vld high, sample dropped), then 8x +1
    do_reset();
    feed(1, 3);
    feed(7, 3);
    chk("t5_pre_dat", dat_a, 24);
    pulses = 0;
    feed(5, 7);
    clr    = 1'b1;
    in_vld = 1'b1;
    in_dat = 11'd7;
    tick();
    clr    = 1'b0;
    chk("t5_clr_vld", vld_a, 0);
    chk("t5_clr_hold", dat_a, 24);
    feed(7, 1);
    chk("t5_no_early_vld", vld_a, 0);
    feed(1, 1);
    chk("t5_vld", vld_a, 1);
    chk("t5_dat", dat_a, 8);
    in_vld = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("t5_pulses", pulses, 1);

    // T6: reset mid-block discards partial sum, then two continuous blocks
    do_reset();
    feed(3, 2);
    rst_n  = 1'b0;
    in_vld = 1'b1;
    tick();
    rst_n  = 1'b1;
    pulses = 0;
    first_t  = -1;
    second_t = -1;
    for (int i = 0; i < 20; i++) begin
      in_vld = (i < 16);
      in_dat = 11'd2;
      tick();
      if (vld_a === 1'b1) begin
        chk("t6_dat", dat_a, 16);
        if (first_t < 0) first_t = ticks;
        else second_t = ticks;
      end
    end
    chk("t6_pulses", pulses, 2);
    chk("t6_spacing", second_t - first_t, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
